lcd_capture_rgb565: RTL and testbench

Video-input capture block: receives an RGB565 parallel pixel stream framed by active-high HSync/VSync, in the same timing format our LCD output path generates, and writes one frame of H_ACTIVE×V_ACTIVE pixels linearly into the 16-bit frame RAM. It is the writer-side counterpart of the LCD read path and sits between the camera/video source pins and the frame-RAM write port.

---
 rtl/lcd_capture_rgb565.sv | 174 +++++++++++++++++
 tb/tb_lcd_capture_rgb565.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_capture_rgb565.sv
// rtl/lcd_capture_rgb565.sv - RGB565 HSync/VSync video capture into a linear 16-bit frame RAM
//
// Ports:
//   iClk, iRsn        clock, asynchronous active-low reset
//   iEnClk            pixel-rate enable; sampling and state advance only when high
//   iCapEn            1 = capture frames continuously, 0 = stop after current frame
//   iVidHSync/VSync   active-high line / frame data windows
//   iVidR/G/B         5/6/5 pixel colour
//   oRamWrEn          one-iClk write strobe
//   oRamWrAddr/Data   write address / {R,G,B}, held between writes
//   oBusy             capture engine not idle
//   oFrameDone        one-iClk pulse at end of each captured frame
//   oErr              sticky short-line / short-frame flag, cleared on capture start

module lcd_capture_rgb565 #(
    parameter int H_SKIP   = 2,
    parameter int H_ACTIVE = 480,
    parameter int V_SKIP   = 2,
    parameter int V_ACTIVE = 272
) (
    input  logic        iClk,
    input  logic        iRsn,
    input  logic        iEnClk,
    input  logic        iCapEn,
    input  logic        iVidHSync,
    input  logic        iVidVSync,
    input  logic [4:0]  iVidR,
    input  logic [5:0]  iVidG,
    input  logic [4:0]  iVidB,
    output logic        oRamWrEn,
    output logic [16:0] oRamWrAddr,
    output logic [15:0] oRamWrData,
    output logic        oBusy,
    output logic        oFrameDone,
    output logic        oErr
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARM     = 2'd1;
    localparam logic [1:0] ST_WAIT_V  = 2'd2;
    localparam logic [1:0] ST_CAPTURE = 2'd3;

    localparam logic [16:0] H_LO     = 17'(H_SKIP);
    localparam logic [16:0] H_HI     = 17'(H_SKIP + H_ACTIVE);
    localparam logic [16:0] V_LO     = 17'(V_SKIP);
    localparam logic [16:0] V_HI     = 17'(V_SKIP + V_ACTIVE);
    localparam logic [16:0] ROW_STEP = 17'(H_ACTIVE);
    localparam logic [15:0] H_SKIP16 = 16'(H_SKIP);

    logic [1:0]  state;

    // input stage and one-sample history for edge detection
    logic        hs_q, vs_q, hs_d, vs_d;
    logic [15:0] pix_q;

    logic [15:0] hpix;
    logic [15:0] line;
    logic [16:0] row_base;

    logic        hs_rise, hs_fall, vs_rise, vs_fall;
    logic [15:0] cur_hpix, hpix_inc, line_inc, line_after, col;
    logic        line_act, pix_act, wr_hit, line_short, frame_short;
    logic [16:0] wr_addr;

    always_comb begin
        hs_rise     = hs_q & ~hs_d;
        hs_fall     = ~hs_q & hs_d;
        vs_rise     = vs_q & ~vs_d;
        vs_fall     = ~vs_q & vs_d;
        // the sample that carries the HSync rise is pixel 0 of the line
        cur_hpix    = hs_rise ? 16'd0 : hpix;
        hpix_inc    = (cur_hpix == 16'hFFFF) ? cur_hpix : cur_hpix + 16'd1;
        line_inc    = (line == 16'hFFFF) ? line : line + 16'd1;
        line_act    = ({1'b0, line} >= V_LO) && ({1'b0, line} < V_HI);
        pix_act     = ({1'b0, cur_hpix} >= H_LO) && ({1'b0, cur_hpix} < H_HI);
        wr_hit      = (state == ST_CAPTURE) && vs_q && hs_q && line_act && pix_act;
        col         = cur_hpix - H_SKIP16;
        wr_addr     = row_base + {1'b0, col};
        // hpix holds the sample count of the line just ended
        line_short  = hs_fall && line_act && ({1'b0, hpix} < H_HI);
        // a coincident line end counts toward the frame's line total
        line_after  = hs_fall ? line_inc : line;
        frame_short = ({1'b0, line_after} < V_HI);
    end

    assign oBusy = (state != ST_IDLE);

    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            state      <= ST_IDLE;
            hs_q       <= 1'b0;
            vs_q       <= 1'b0;
            hs_d       <= 1'b0;
            vs_d       <= 1'b0;
            pix_q      <= 16'd0;
            hpix       <= 16'd0;
            line       <= 16'd0;
            row_base   <= 17'd0;
            oRamWrEn   <= 1'b0;
            oRamWrAddr <= 17'd0;
            oRamWrData <= 16'd0;
            oFrameDone <= 1'b0;
            oErr       <= 1'b0;
        end else begin
            // strobes last exactly one iClk regardless of the enable
            oRamWrEn   <= 1'b0;
            oFrameDone <= 1'b0;
            if (iEnClk) begin
                hs_q  <= iVidHSync;
                vs_q  <= iVidVSync;
                hs_d  <= hs_q;
                vs_d  <= vs_q;
                pix_q <= {iVidR, iVidG, iVidB};

                if (wr_hit) begin
                    oRamWrEn   <= 1'b1;
                    oRamWrAddr <= wr_addr;
                    oRamWrData <= pix_q;
                end

                case (state)
                    ST_IDLE: begin
                        if (iCapEn) begin
                            state <= ST_ARM;
                            oErr  <= 1'b0;
                        end
                    end
                    ST_ARM: begin
                        // wait out any frame already in progress
                        if (!iCapEn) begin
                            state <= ST_IDLE;
                        end else if (!vs_q) begin
                            state <= ST_WAIT_V;
                        end
                    end
                    ST_WAIT_V: begin
                        if (!iCapEn) begin
                            state <= ST_IDLE;
                        end else if (vs_rise) begin
                            state    <= ST_CAPTURE;
                            hpix     <= 16'd0;
                            line     <= 16'd0;
                            row_base <= 17'd0;
                        end
                    end
                    ST_CAPTURE: begin
                        if (hs_q) begin
                            hpix <= hpix_inc;
                        end
                        if (hs_fall) begin
                            line <= line_inc;
                            // realign to the next row even when this line was short
                            if (line_act) begin
                                row_base <= row_base + ROW_STEP;
                            end
                            if (line_short) begin
                                oErr <= 1'b1;
                            end
                        end
                        if (vs_fall) begin
                            oFrameDone <= 1'b1;
                            if (frame_short) begin
                                oErr <= 1'b1;
                            end
                            state <= iCapEn ? ST_WAIT_V : ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lcd_capture_rgb565.sv
// tb/tb_lcd_capture_rgb565.sv - randomized self-checking bench for lcd_capture_rgb565
`timescale 1ns/1ps
module tb_lcd_capture_rgb565;

    localparam int HS = 2;
    localparam int HA = 4;
    localparam int VS = 1;
    localparam int VA = 3;

    logic        iClk = 1'b0;
    logic        iRsn = 1'b0;
    logic        iEnClk = 1'b1;
    logic        iCapEn = 1'b0;
    logic        iVidHSync = 1'b0;
    logic        iVidVSync = 1'b0;
    logic [4:0]  iVidR = 5'd0;
    logic [5:0]  iVidG = 6'd0;
    logic [4:0]  iVidB = 5'd0;
    logic        oRamWrEn;
    logic [16:0] oRamWrAddr;
    logic [15:0] oRamWrData;
    logic        oBusy;
    logic        oFrameDone;
    logic        oErr;

    lcd_capture_rgb565 #(
        .H_SKIP(HS), .H_ACTIVE(HA), .V_SKIP(VS), .V_ACTIVE(VA)
    ) dut (
        .iClk(iClk), .iRsn(iRsn), .iEnClk(iEnClk), .iCapEn(iCapEn),
        .iVidHSync(iVidHSync), .iVidVSync(iVidVSync),
        .iVidR(iVidR), .iVidG(iVidG), .iVidB(iVidB),
        .oRamWrEn(oRamWrEn), .oRamWrAddr(oRamWrAddr), .oRamWrData(oRamWrData),
        .oBusy(oBusy), .oFrameDone(oFrameDone), .oErr(oErr)
    );

    always #5 iClk = ~iClk;

    int n_checks = 0;
    int n_errs   = 0;
    int en_div   = 1;
    int drop_line = -1;
    int rst_line  = -1;
    int joint_end = 0;

    int          nsamp [8];
    logic [15:0] pix [8][8];
    logic [16:0] got_addr[$];
    logic [15:0] got_data[$];
    logic [16:0] exp_addr[$];
    logic [15:0] exp_data[$];
    logic        exp_err;
    int          fd_cnt = 0;
    int          fd_wr = -1;
    int          consec = 0;
    logic        prev_we = 1'b0;
    logic [36:0] rst_snap;

    always @(negedge iClk) begin
        if (oRamWrEn) begin
            got_addr.push_back(oRamWrAddr);
            got_data.push_back(oRamWrData);
            if (prev_we) consec++;
        end
        prev_we = oRamWrEn;
        if (oFrameDone) begin
            fd_cnt++;
            fd_wr = got_addr.size();
        end
    end

    task automatic clear_mon();
        got_addr.delete();
        got_data.delete();
        fd_cnt = 0;
        fd_wr  = -1;
        consec = 0;
    endtask

    task automatic sample(input logic hs, input logic vs, input logic [15:0] px);
        iVidHSync = hs;
        iVidVSync = vs;
        {iVidR, iVidG, iVidB} = px;
        for (int i = 1; i < en_div; i++) begin
            iEnClk = 1'b0;
            @(posedge iClk);
            #1;
        end
        iEnClk = 1'b1;
        @(posedge iClk);
        #1;
    endtask

    task automatic fill(input int nl, input bit clean);
        for (int l = 0; l < 8; l++) begin
            nsamp[l] = HS + HA;
            for (int h = 0; h < 8; h++)
                pix[l][h] = clean ? 16'(l * 16 + h) : 16'($urandom);
        end
    endtask

    task automatic send_frame(input int nl);
        for (int i = 0; i < 3; i++) sample(1'b0, 1'b0, 16'd0);
        for (int i = 0; i < 2; i++) sample(1'b0, 1'b1, 16'd0);
        for (int l = 0; l < nl; l++) begin
            if (l == drop_line) iCapEn = 1'b0;
            for (int h = 0; h < nsamp[l]; h++) begin
                if (l == rst_line && h == 3) begin
                    iRsn = 1'b0;
                    #2;
                    rst_snap = {oRamWrEn, oRamWrAddr, oRamWrData, oBusy, oFrameDone, oErr};
                    clear_mon();
                    #2;
                    iRsn = 1'b1;
                end
                sample(1'b1, 1'b1, pix[l][h]);
            end
            if (!(joint_end != 0 && l == nl - 1))
                for (int i = 0; i < 2; i++) sample(1'b0, 1'b1, 16'd0);
        end
        for (int i = 0; i < 4; i++) sample(1'b0, 1'b0, 16'd0);
    endtask

    // Expected writes straight from the window rule: line L, pixel h lands at
    // (L-VS)*HA + (h-HS) when both fall inside the active window.
    task automatic model(input int nl);
        exp_addr.delete();
        exp_data.delete();
        exp_err = (nl < VS + VA);
        for (int l = 0; l < nl; l++) begin
            if (l >= VS && l < VS + VA) begin
                if (nsamp[l] < HS + HA) exp_err = 1'b1;
                for (int h = HS; h < HS + HA && h < nsamp[l]; h++) begin
                    exp_addr.push_back(17'((l - VS) * HA + (h - HS)));
                    exp_data.push_back(pix[l][h]);
                end
            end
        end
    endtask

    function automatic int seq_bad();
        int b = 0;
        if (got_addr.size() != exp_addr.size()) return -1;
        for (int i = 0; i < got_addr.size(); i++)
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) b++;
        return b;
    endfunction

    task automatic test_reset();
        iRsn = 1'b0;
        iCapEn = 1'b1;
        iVidHSync = 1'b1;
        iVidVSync = 1'b1;
        repeat (3) @(posedge iClk);
        #1;
        n_checks++;
        if ({oRamWrEn, oBusy, oFrameDone, oErr} !== 4'b0) begin
            n_errs++;
            $display("FAIL reset_flags: got %b expected 0000", {oRamWrEn, oBusy, oFrameDone, oErr});
        end
        n_checks++;
        if ({oRamWrAddr, oRamWrData} !== 33'd0) begin
            n_errs++;
            $display("FAIL reset_addr_data: got %h expected 0", {oRamWrAddr, oRamWrData});
        end
        iCapEn = 1'b0;
        iVidHSync = 1'b0;
        iVidVSync = 1'b0;
        @(posedge iClk);
        #1;
        iRsn = 1'b1;
        sample(1'b0, 1'b0, 16'd0);
    endtask

    task automatic test_clean_frame();
        int b;
        clear_mon();
        fill(4, 1'b1);
        iCapEn = 1'b1;
        send_frame(4);
        model(4);
        b = seq_bad();
        n_checks++;
        if (got_addr.size() != 12) begin
            n_errs++;
            $display("FAIL clean_count: got %0d expected 12", got_addr.size());
        end
        n_checks++;
        if (b != 0) begin
            n_errs++;
            $display("FAIL clean_seq: got %0d bad entries expected 0", b);
        end
        n_checks++;
        if (fd_cnt != 1 || fd_wr != 12) begin
            n_errs++;
            $display("FAIL clean_done: got pulses=%0d writes_at_done=%0d expected 1 and 12", fd_cnt, fd_wr);
        end
        n_checks++;
        if (oErr !== 1'b0 || oBusy !== 1'b1) begin
            n_errs++;
            $display("FAIL clean_status: got err=%b busy=%b expected 0 1", oErr, oBusy);
        end
    endtask

    task automatic test_partial_start();
        int b;
        iRsn = 1'b0;
        iCapEn = 1'b1;
        iVidVSync = 1'b1;
        @(posedge iClk);
        #1;
        iRsn = 1'b1;
        clear_mon();
        for (int l = 0; l < 2; l++) begin
            for (int h = 0; h < 6; h++) sample(1'b1, 1'b1, 16'($urandom));
            for (int i = 0; i < 2; i++) sample(1'b0, 1'b1, 16'd0);
        end
        fill(4, 1'b0);
        send_frame(4);
        model(4);
        b = seq_bad();
        n_checks++;
        if (b != 0) begin
            n_errs++;
            $display("FAIL partial_seq: got %0d (writes=%0d) expected 0", b, got_addr.size());
        end
        n_checks++;
        if (fd_cnt != 1) begin
            n_errs++;
            $display("FAIL partial_done: got %0d expected 1", fd_cnt);
        end
    endtask

    task automatic test_short_line();
        int b;
        clear_mon();
        fill(4, 1'b1);
        nsamp[2] = 4;
        send_frame(4);
        model(4);
        b = seq_bad();
        n_checks++;
        if (b != 0) begin
            n_errs++;
            $display("FAIL short_seq: got %0d (writes=%0d) expected 0", b, got_addr.size());
        end
        n_checks++;
        if (oErr !== exp_err) begin
            n_errs++;
            $display("FAIL short_err: got %b expected %b", oErr, exp_err);
        end
        clear_mon();
        fill(4, 1'b1);
        drop_line = 0;
        send_frame(4);
        drop_line = -1;
        n_checks++;
        if (oErr !== 1'b1 || oBusy !== 1'b0 || got_addr.size() != 12) begin
            n_errs++;
            $display("FAIL short_sticky: got err=%b busy=%b writes=%0d expected 1 0 12", oErr, oBusy, got_addr.size());
        end
        iCapEn = 1'b1;
        sample(1'b0, 1'b0, 16'd0);
        n_checks++;
        if (oErr !== 1'b0 || oBusy !== 1'b1) begin
            n_errs++;
            $display("FAIL short_clear: got err=%b busy=%b expected 0 1", oErr, oBusy);
        end
    endtask

    task automatic test_enclk_div();
        int b;
        en_div = 3;
        clear_mon();
        fill(4, 1'b0);
        send_frame(4);
        model(4);
        b = seq_bad();
        en_div = 1;
        n_checks++;
        if (b != 0) begin
            n_errs++;
            $display("FAIL div_seq: got %0d (writes=%0d) expected 0", b, got_addr.size());
        end
        n_checks++;
        if (consec != 0 || fd_cnt != 1) begin
            n_errs++;
            $display("FAIL div_strobe: got wide=%0d done=%0d expected 0 1", consec, fd_cnt);
        end
    endtask

    task automatic test_capen_drop();
        int b;
        clear_mon();
        fill(4, 1'b0);
        drop_line = 2;
        send_frame(4);
        drop_line = -1;
        model(4);
        b = seq_bad();
        n_checks++;
        if (b != 0 || fd_cnt != 1) begin
            n_errs++;
            $display("FAIL drop_frame: got bad=%0d done=%0d expected 0 1", b, fd_cnt);
        end
        n_checks++;
        if (oBusy !== 1'b0) begin
            n_errs++;
            $display("FAIL drop_busy: got %b expected 0", oBusy);
        end
        clear_mon();
        fill(4, 1'b0);
        send_frame(4);
        n_checks++;
        if (got_addr.size() != 0 || fd_cnt != 0) begin
            n_errs++;
            $display("FAIL drop_idle: got writes=%0d done=%0d expected 0 0", got_addr.size(), fd_cnt);
        end
        iCapEn = 1'b1;
    endtask

    task automatic test_reset_mid();
        int b;
        clear_mon();
        fill(4, 1'b0);
        rst_line = 2;
        send_frame(4);
        rst_line = -1;
        n_checks++;
        if (rst_snap !== 37'd0) begin
            n_errs++;
            $display("FAIL rstmid_outputs: got %h expected 0", rst_snap);
        end
        n_checks++;
        if (got_addr.size() != 0 || fd_cnt != 0) begin
            n_errs++;
            $display("FAIL rstmid_quiet: got writes=%0d done=%0d expected 0 0", got_addr.size(), fd_cnt);
        end
        clear_mon();
        fill(4, 1'b0);
        send_frame(4);
        model(4);
        b = seq_bad();
        n_checks++;
        if (b != 0 || fd_cnt != 1) begin
            n_errs++;
            $display("FAIL rstmid_restart: got bad=%0d done=%0d expected 0 1", b, fd_cnt);
        end
    endtask

    task automatic test_random();
        int   b;
        int   nl;
        logic acc = 1'b0;
        for (int f = 0; f < 8; f++) begin
            clear_mon();
            nl = $urandom_range(6, 3);
            fill(nl, 1'b0);
            for (int l = 0; l < nl; l++) nsamp[l] = $urandom_range(8, 4);
            joint_end = $urandom_range(1, 0);
            send_frame(nl);
            joint_end = 0;
            model(nl);
            acc = acc | exp_err;
            b = seq_bad();
            n_checks++;
            if (b != 0) begin
                n_errs++;
                $display("FAIL rand_seq[%0d]: got %0d (writes=%0d) expected 0", f, b, got_addr.size());
            end
            n_checks++;
            if (fd_cnt != 1 || oErr !== acc) begin
                n_errs++;
                $display("FAIL rand_status[%0d]: got done=%0d err=%b expected 1 %b", f, fd_cnt, oErr, acc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_frame();
        test_partial_start();
        test_short_line();
        test_enclk_div();
        test_capen_drop();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
